// File: rtl/scratchpad_bus_arbiter.sv
// scratchpad_bus_arbiter
//   Round-robin 2:1 arbiter in front of the SoC scratchpad. m0 is the CPU and m1 is the
//   debug/UART loader. Only one transaction is in flight at a time. A watchdog completes the
//   requester handshake with ERR_DATA if the memory never answers.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_IDLE  | no transaction; pick a winner and latch its request
//   S_GRANT | o_mem_valid high, waiting for i_mem_ready or the watchdog
//   S_RESP  | one-cycle o_mN_ready pulse to the granted requester
//
// Ports
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_mN_valid/we/addr/wdata/wstrb    requester N request (N=0,1)
//   o_mN_ready, o_mN_rdata            requester N completion pulse and read data
//   o_mem_valid/we/addr/wdata/wstrb   registered request to the scratchpad
//   i_mem_ready, i_mem_rdata          scratchpad completion and read data
//   o_timeout                         one-cycle pulse when the watchdog fires
module scratchpad_bus_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned TIMEOUT  = 1024,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_m0_valid,
  input  logic              i_m0_we,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [31:0]       i_m0_wdata,
  input  logic [3:0]        i_m0_wstrb,
  output logic              o_m0_ready,
  output logic [31:0]       o_m0_rdata,
  input  logic              i_m1_valid,
  input  logic              i_m1_we,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [31:0]       i_m1_wdata,
  input  logic [3:0]        i_m1_wstrb,
  output logic              o_m1_ready,
  output logic [31:0]       o_m1_rdata,
  output logic              o_mem_valid,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_wstrb,
  input  logic              i_mem_ready,
  input  logic [31:0]       i_mem_rdata,
  output logic              o_timeout
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam bit WD_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = WD_EN ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RESP} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_last_grant;
  logic              r_grant;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_timeout;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic [3:0]        r_mem_wstrb;
  logic [31:0]       r_m0_rdata;
  logic [31:0]       r_m1_rdata;

  logic              w_load;
  logic              w_sel;
  logic              w_done;
  logic              w_fire;
  logic [31:0]       w_rsp_data;

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_sel        = 1'b0;
    w_done       = 1'b0;
    w_fire       = 1'b0;
    o_mem_valid  = 1'b0;
    o_m0_ready   = 1'b0;
    o_m1_ready   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_m0_valid || i_m1_valid) begin
          w_load = 1'b1;
          // On a tie the requester that did not win last time goes first.
          if (i_m0_valid && i_m1_valid) w_sel = ~r_last_grant;
          else                          w_sel = i_m1_valid;
          w_next_state = S_GRANT;
        end
      end
      S_GRANT: begin
        o_mem_valid = 1'b1;
        // A ready arriving on the last watchdog cycle still counts as a normal completion.
        if (i_mem_ready) begin
          w_done       = 1'b1;
          w_next_state = S_RESP;
        end else if (WD_EN && (r_cnt == CNT_LAST)) begin
          w_fire       = 1'b1;
          w_next_state = S_RESP;
        end
      end
      S_RESP: begin
        o_m0_ready   = ~r_grant;
        o_m1_ready   = r_grant;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_rsp_data = r_mem_we ? 32'h0 : (w_done ? i_mem_rdata : ERR_DATA);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_cnt        <= '0;
      r_timeout    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_wstrb  <= '0;
      r_m0_rdata   <= '0;
      r_m1_rdata   <= '0;
    end else begin
      r_state   <= w_next_state;
      r_timeout <= w_fire;
      r_cnt     <= ((r_state == S_GRANT) && (w_next_state == S_GRANT)) ? r_cnt + 1'b1 : '0;
      if (w_load) begin
        r_grant      <= w_sel;
        r_last_grant <= w_sel;
        r_mem_we     <= w_sel ? i_m1_we    : i_m0_we;
        r_mem_addr   <= w_sel ? i_m1_addr  : i_m0_addr;
        r_mem_wdata  <= w_sel ? i_m1_wdata : i_m0_wdata;
        r_mem_wstrb  <= w_sel ? i_m1_wstrb : i_m0_wstrb;
      end
      if (w_done || w_fire) begin
        if (r_grant) r_m1_rdata <= w_rsp_data;
        else         r_m0_rdata <= w_rsp_data;
      end
    end
  end

  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_wstrb = r_mem_wstrb;
  assign o_m0_rdata  = r_m0_rdata;
  assign o_m1_rdata  = r_m1_rdata;
  assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_scratchpad_bus_arbiter.sv
module tb_scratchpad_bus_arbiter;
  localparam int TO = 8;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_m0_valid, i_m0_we, i_m1_valid, i_m1_we;
  logic [31:0] i_m0_addr, i_m0_wdata, i_m1_addr, i_m1_wdata;
  logic [3:0]  i_m0_wstrb, i_m1_wstrb;
  logic        o_m0_ready, o_m1_ready;
  logic [31:0] o_m0_rdata, o_m1_rdata;
  logic        o_mem_valid, o_mem_we;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_wstrb;
  logic        i_mem_ready;
  logic [31:0] i_mem_rdata;
  logic        o_timeout;

  scratchpad_bus_arbiter #(.ADDR_W(32), .TIMEOUT(TO), .ERR_DATA(32'hDEADBEEF)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_m0_valid(i_m0_valid), .i_m0_we(i_m0_we), .i_m0_addr(i_m0_addr),
    .i_m0_wdata(i_m0_wdata), .i_m0_wstrb(i_m0_wstrb),
    .o_m0_ready(o_m0_ready), .o_m0_rdata(o_m0_rdata),
    .i_m1_valid(i_m1_valid), .i_m1_we(i_m1_we), .i_m1_addr(i_m1_addr),
    .i_m1_wdata(i_m1_wdata), .i_m1_wstrb(i_m1_wstrb),
    .o_m1_ready(o_m1_ready), .o_m1_rdata(o_m1_rdata),
    .o_mem_valid(o_mem_valid), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb),
    .i_mem_ready(i_mem_ready), .i_mem_rdata(i_mem_rdata),
    .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  // Transaction-level reference state.
  bit          pend [2];
  bit          q_we [2];
  logic [31:0] q_addr [2];
  logic [31:0] q_wdata [2];
  logic [3:0]  q_wstrb [2];
  logic [31:0] last_rd [2];
  int          lg;
  int          grants [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic new_req(input int n, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
    pend[n] = 1'b1; q_we[n] = we; q_addr[n] = addr; q_wdata[n] = wdata; q_wstrb[n] = wstrb;
  endtask

  task automatic drive_reqs();
    i_m0_valid = pend[0]; i_m0_we = q_we[0]; i_m0_addr = q_addr[0];
    i_m0_wdata = q_wdata[0]; i_m0_wstrb = q_wstrb[0];
    i_m1_valid = pend[1]; i_m1_we = q_we[1]; i_m1_addr = q_addr[1];
    i_m1_wdata = q_wdata[1]; i_m1_wstrb = q_wstrb[1];
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mv"},  o_mem_valid, 0);
    chk({tag, "_r0"},  o_m0_ready, 0);
    chk({tag, "_r1"},  o_m1_ready, 0);
    chk({tag, "_to"},  o_timeout, 0);
    chk({tag, "_we"},  o_mem_we, 0);
    chk({tag, "_ad"},  o_mem_addr, 0);
    chk({tag, "_wd"},  o_mem_wdata, 0);
    chk({tag, "_ws"},  o_mem_wstrb, 0);
    chk({tag, "_d0"},  o_m0_rdata, 0);
    chk({tag, "_d1"},  o_m1_rdata, 0);
  endtask

  // One arbitration round, entered at a negedge while the arbiter is idle. The memory
  // answers d cycles after o_mem_valid rises (d >= TO means never) with data rd.
  task automatic txn(input int d, input logic [31:0] rd);
    int  w;
    int  o;
    bit  timed;
    logic [31:0] exp_rd;
    drive_reqs();
    i_mem_ready = 1'b1;              // idle-time ready must be ignored
    @(posedge i_clk); @(negedge i_clk);
    i_mem_ready = 1'b0;
    if (!pend[0] && !pend[1]) begin
      chk("idle_mv", o_mem_valid, 0);
      return;
    end
    w = (pend[0] && pend[1]) ? (lg == 1 ? 0 : 1) : (pend[0] ? 0 : 1);
    o = 1 - w;
    lg = w;
    grants.push_back(w);
    chk("mem_we", o_mem_we, q_we[w]);
    chk("mem_addr", o_mem_addr, q_addr[w]);
    chk("mem_wdata", o_mem_wdata, q_wdata[w]);
    chk("mem_wstrb", o_mem_wstrb, q_wstrb[w]);
    for (int k = 0; k < TO; k++) begin
      chk("grant_mv", o_mem_valid, 1);
      chk("grant_rdy", {o_m0_ready, o_m1_ready}, 0);
      chk("grant_addr", o_mem_addr, q_addr[w]);
      if (k == d) begin i_mem_ready = 1'b1; i_mem_rdata = rd; end
      @(posedge i_clk); @(negedge i_clk);
      i_mem_ready = 1'b0; i_mem_rdata = $urandom;
      if (k == d) break;
    end
    timed  = (d > TO - 1);
    exp_rd = q_we[w] ? 32'h0 : (timed ? 32'hDEADBEEF : rd);
    chk("resp_mv", o_mem_valid, 0);
    chk("resp_rdy_w", w ? o_m1_ready : o_m0_ready, 1);
    chk("resp_rdy_o", o ? o_m1_ready : o_m0_ready, 0);
    chk("resp_rdata", w ? o_m1_rdata : o_m0_rdata, exp_rd);
    chk("hold_rdata", o ? o_m1_rdata : o_m0_rdata, last_rd[o]);
    chk("resp_to", o_timeout, timed);
    last_rd[w] = exp_rd;
    pend[w] = 1'b0;
    drive_reqs();
    @(posedge i_clk); @(negedge i_clk);
    chk("post_rdy", {o_m0_ready, o_m1_ready}, 0);
    chk("post_to", o_timeout, 0);
  endtask

  initial begin
    int b;
    int w;
    pend[0] = 0; pend[1] = 0;
    for (int n = 0; n < 2; n++) begin
      q_we[n] = 0; q_addr[n] = 0; q_wdata[n] = 0; q_wstrb[n] = 0; last_rd[n] = 0;
    end
    lg = 1;
    i_rst = 1'b1; i_mem_ready = 1'b0; i_mem_rdata = 0;
    drive_reqs();
    repeat (3) @(negedge i_clk);
    chk_all_zero("reset");
    i_rst = 1'b0;

    // Ties straight after reset: grants must alternate starting with m0.
    new_req(0, 0, 32'h0000_0400, 0, 4'h0);
    new_req(1, 0, 32'h0000_0800, 0, 4'h0);
    txn(0, 32'h1111_0001);
    new_req(0, 0, 32'h0000_0404, 0, 4'h0);
    txn(1, 32'h1111_0002);
    new_req(1, 0, 32'h0000_0804, 0, 4'h0);
    txn(0, 32'h1111_0003);
    new_req(0, 0, 32'h0000_0408, 0, 4'h0);
    txn(2, 32'h1111_0004);
    b = 0;
    while (grants.size() > 0) begin
      w = grants.pop_front();
      chk("tie_order", w, b % 2);
      b++;
    end
    txn(0, 32'h1111_0005);           // leftover m0
    void'(grants.pop_front());

    // Plain m0 read, memory answers after 3 cycles.
    new_req(0, 0, 32'h0000_0100, 32'h0, 4'h0);
    txn(3, 32'h1234_5678);
    chk("t1_rdata", o_m0_rdata, 32'h1234_5678);

    // m1 write: response data is zero.
    new_req(1, 1, 32'h0000_0020, 32'hA5A5_5A5A, 4'b0011);
    txn(1, 32'hFFFF_FFFF);

    // Watchdog: memory never answers, then ready coincident with the last watchdog cycle.
    new_req(0, 0, 32'h0000_0200, 0, 4'h0);
    txn(100, 32'h0);
    new_req(0, 0, 32'h0000_0204, 0, 4'h0);
    txn(TO - 1, 32'hCAFE_F00D);

    // Reset in the middle of a grant abandons it with no ready pulse.
    new_req(0, 0, 32'h0000_0300, 0, 4'h0);
    drive_reqs();
    @(posedge i_clk); @(negedge i_clk);
    chk("rst_pre_mv", o_mem_valid, 1);
    lg = 0;
    i_rst = 1'b1;
    @(posedge i_clk); @(negedge i_clk);
    chk_all_zero("rst_mid");
    i_rst = 1'b0;
    lg = 1; last_rd[0] = 0; last_rd[1] = 0;
    new_req(1, 0, 32'h0000_0900, 0, 4'h0);
    txn(0, 32'h5555_0001);
    chk("rst_grant_m0", o_m0_rdata, 32'h5555_0001);

    // Zero-wait memory, m0 keeps asking, m1 joins and must get in next.
    new_req(0, 0, 32'h0000_0500, 0, 4'h0);
    txn(0, 32'h6666_0001);           // services the m1 left pending above
    new_req(0, 0, 32'h0000_0504, 0, 4'h0);
    txn(0, 32'h6666_0002);
    new_req(0, 0, 32'h0000_0508, 0, 4'h0);
    new_req(1, 0, 32'h0000_0A00, 0, 4'h0);
    txn(0, 32'h6666_0003);
    new_req(0, 0, 32'h0000_050C, 0, 4'h0);
    txn(0, 32'h6666_0004);
    grants.delete();

    // Random traffic.
    for (int it = 0; it < 60; it++) begin
      for (int n = 0; n < 2; n++)
        if (!pend[n] && ($urandom_range(0, 2) != 0))
          new_req(n, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
      txn($urandom_range(0, 10), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "time limit");
  end
endmodule
